// File: rtl/video_scale_pkg.sv
// Shared types and helpers for the video scaler blocks: FSM states, default sizes
// and the resolution sanity check applied when a new frame configuration is latched.
package video_scale_pkg;

  localparam int VS_DW       = 25;
  localparam int VS_MAX_XRES = 1920;

  typedef enum logic [1:0] {
    WAIT_VS,
    FILL,
    EMIT,
    DROP
  } state_t;

  typedef struct packed {
    logic [15:0] vin_xres;
    logic [15:0] vin_yres;
    logic [15:0] vout_xres;
    logic [15:0] vout_yres;
  } cfg_t;

  // Upscale only: every resolution non-zero, output no smaller than input, and the
  // input line must fit in the line buffer.
  function automatic logic cfg_valid(input cfg_t cfg, input int unsigned max_xres);
    return (cfg.vin_xres != 16'd0) && (cfg.vin_yres != 16'd0) &&
           (cfg.vout_xres != 16'd0) && (cfg.vout_yres != 16'd0) &&
           (cfg.vout_xres >= cfg.vin_xres) && (cfg.vout_yres >= cfg.vin_yres) &&
           (32'(cfg.vin_xres) <= max_xres);
  endfunction

endpackage

// File: rtl/video_scale_up_near_if.sv
// Pixel stream handshake bundle: data, valid and ready, with producer (master)
// and consumer (slave) views.
interface video_scale_up_near_if
  import video_scale_pkg::*;
#(
  parameter int DW = VS_DW
);
  logic [DW-1:0] dat;
  logic          valid;
  logic          ready;

  modport master (output dat, output valid, input ready);
  modport slave  (input dat, input valid, output ready);
endinterface

// File: rtl/video_line_buf.sv
// One-line pixel store: simple dual-port RAM, one write port and one read port
// with a single registered read stage.
module video_line_buf #(
  parameter int DW    = 25,
  parameter int DEPTH = 1920,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_dat,
  input  logic          re,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dat
);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: the RAM and its read register have no reset so they map onto block RAM;
  // nothing downstream consumes rd_dat until a read has actually been issued.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_dat;
    if (re) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/video_scale_up_near.sv
// Nearest-neighbour video upscaler: buffers one input line and replays it with
// horizontal pixel and vertical line repetition. Build option
// VIDEO_SCALE_UP_EOL_FLAG_EN turns vout_dat[24] into an end-of-line marker.
module video_scale_up_near
  import video_scale_pkg::*;
#(
  parameter int DW       = VS_DW,
  parameter int MAX_XRES = VS_MAX_XRES,
  parameter int AW       = 11
) (
  input  logic                  vin_clk,
  input  logic                  rst_n,
  input  logic                  frame_vs,
  video_scale_up_near_if.slave  vin,
  video_scale_up_near_if.master vout,
  input  logic [15:0]           vin_xres,
  input  logic [15:0]           vin_yres,
  input  logic [15:0]           vout_xres,
  input  logic [15:0]           vout_yres,
  output logic                  cfg_err
);

  state_t        state_q, state_d;
  cfg_t          cfg_q, cfg_new;
  logic          cfg_new_ok;
  logic          vs_d, vs_rise;

  logic [AW-1:0] wr_addr_q, rd_addr_q;
  logic [16:0]   hacc_q, vacc_q, hacc_sum, vacc_sum;
  logic          hacc_wrap, vacc_wrap;
  logic [15:0]   rd_cnt_q, orow_q, orow_inc;
  logic          rd_pend_q;

  logic [DW-1:0] fifo_mem_q [2];
  logic [1:0]    fifo_cnt_q;
  logic          fifo_wr_q, fifo_rd_q;
  logic [2:0]    fifo_level;

  logic          in_fire, out_fire, line_write, wr_last, rd_issue, line_done;
  logic [DW-1:0] buf_rd_dat, push_dat;

  assign cfg_new    = '{vin_xres: vin_xres, vin_yres: vin_yres,
                        vout_xres: vout_xres, vout_yres: vout_yres};
  assign cfg_new_ok = cfg_valid(cfg_new, MAX_XRES);
  assign vs_rise    = frame_vs & ~vs_d;

  assign in_fire    = vin.valid & vin.ready;
  assign out_fire   = vout.valid & vout.ready;
  assign line_write = (state_q == FILL) & in_fire & ~vs_rise;
  assign wr_last    = (16'(wr_addr_q) == cfg_q.vin_xres - 16'd1);

  // Occupancy counts the pop happening this cycle so a steady stream needs no gaps.
  assign fifo_level = 3'(fifo_cnt_q) + 3'(rd_pend_q) - 3'(out_fire);
  assign rd_issue   = (state_q == EMIT) & ~vs_rise & (rd_cnt_q != cfg_q.vout_xres) &
                      (fifo_level < 3'd2);
  assign line_done  = (state_q == EMIT) & (rd_cnt_q == cfg_q.vout_xres) & ~rd_pend_q &
                      (fifo_cnt_q == 2'd1) & out_fire;

  assign hacc_sum   = hacc_q + 17'(cfg_q.vin_xres);
  assign hacc_wrap  = (hacc_sum >= 17'(cfg_q.vout_xres));
  assign vacc_sum   = vacc_q + 17'(cfg_q.vin_yres);
  assign vacc_wrap  = (vacc_sum >= 17'(cfg_q.vout_yres));
  assign orow_inc   = orow_q + 16'd1;

  video_line_buf #(
    .DW    (DW),
    .DEPTH (MAX_XRES),
    .AW    (AW)
  ) u_line_buf (
    .clk     (vin_clk),
    .we      (line_write),
    .wr_addr (wr_addr_q),
    .wr_dat  (vin.dat),
    .re      (rd_issue),
    .rd_addr (rd_addr_q),
    .rd_dat  (buf_rd_dat)
  );

`ifdef VIDEO_SCALE_UP_EOL_FLAG_EN
  logic rd_eol_q;

  always_ff @(posedge vin_clk or negedge rst_n) begin
    if (!rst_n) rd_eol_q <= 1'b0;
    else        rd_eol_q <= rd_issue & (rd_cnt_q == cfg_q.vout_xres - 16'd1);
  end

  assign push_dat = {rd_eol_q, buf_rd_dat[DW-2:0]};
`else
  assign push_dat = buf_rd_dat;
`endif

  always_ff @(posedge vin_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d    <= 1'b0;
      state_q <= WAIT_VS;
    end else begin
      vs_d    <= frame_vs;
      state_q <= state_d;
    end
  end

  // NOTE: always_comb gives every output a default before the case so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    vin.ready = 1'b1;
    unique case (state_q)
      WAIT_VS: ;
      FILL: if (line_write && wr_last) state_d = EMIT;
      EMIT: begin
        vin.ready = 1'b0;
        if (line_done) begin
          if (orow_inc == cfg_q.vout_yres) state_d = DROP;
          else if (vacc_wrap)              state_d = FILL;
        end
      end
      DROP: ;
      default: state_d = WAIT_VS;
    endcase
    if (vs_rise) state_d = cfg_new_ok ? FILL : DROP;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge vin_clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q         <= '0;
      cfg_err       <= 1'b0;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      hacc_q        <= '0;
      vacc_q        <= '0;
      orow_q        <= '0;
      rd_cnt_q      <= '0;
      rd_pend_q     <= 1'b0;
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      fifo_cnt_q    <= '0;
      fifo_wr_q     <= 1'b0;
      fifo_rd_q     <= 1'b0;
    end else if (vs_rise) begin
      cfg_q      <= cfg_new;
      cfg_err    <= ~cfg_new_ok;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      hacc_q     <= '0;
      vacc_q     <= '0;
      orow_q     <= '0;
      rd_cnt_q   <= '0;
      rd_pend_q  <= 1'b0;
      fifo_cnt_q <= '0;
      fifo_wr_q  <= 1'b0;
      fifo_rd_q  <= 1'b0;
    end else begin
      rd_pend_q <= rd_issue;

      if (line_write) wr_addr_q <= wr_last ? '0 : wr_addr_q + 1'b1;

      if (rd_issue) begin
        rd_cnt_q <= rd_cnt_q + 16'd1;
        if (hacc_wrap) begin
          hacc_q    <= hacc_sum - 17'(cfg_q.vout_xres);
          rd_addr_q <= rd_addr_q + 1'b1;
        end else begin
          hacc_q    <= hacc_sum;
        end
      end

      // Line end: rewind the horizontal walk and step the vertical one.
      if (line_done) begin
        orow_q    <= orow_inc;
        rd_cnt_q  <= '0;
        rd_addr_q <= '0;
        hacc_q    <= '0;
        vacc_q    <= vacc_wrap ? vacc_sum - 17'(cfg_q.vout_yres) : vacc_sum;
      end

      if (rd_pend_q) begin
        fifo_mem_q[fifo_wr_q] <= push_dat;
        fifo_wr_q             <= ~fifo_wr_q;
      end
      if (out_fire) fifo_rd_q <= ~fifo_rd_q;
      fifo_cnt_q <= fifo_cnt_q + 2'(rd_pend_q) - 2'(out_fire);
    end
  end

  assign vout.valid = (fifo_cnt_q != 2'd0);
  assign vout.dat   = fifo_mem_q[fifo_rd_q];

endmodule

// File: tb/tb_video_scale_up_near.sv
// Randomized self-checking bench for video_scale_up_near: expected output comes from
// the closed-form nearest-neighbour mapping applied to the generated input frame.
module tb_video_scale_up_near;

  localparam int DW = 25;

  logic        vin_clk  = 1'b0;
  logic        rst_n    = 1'b0;
  logic        frame_vs = 1'b0;
  logic [15:0] vin_xres = '0, vin_yres = '0, vout_xres = '0, vout_yres = '0;
  logic        cfg_err;

  video_scale_up_near_if #(.DW(DW)) vin_if ();
  video_scale_up_near_if #(.DW(DW)) vout_if ();

  video_scale_up_near #(.DW(DW)) dut (
    .vin_clk   (vin_clk),
    .rst_n     (rst_n),
    .frame_vs  (frame_vs),
    .vin       (vin_if),
    .vout      (vout_if),
    .vin_xres  (vin_xres),
    .vin_yres  (vin_yres),
    .vout_xres (vout_xres),
    .vout_yres (vout_yres),
    .cfg_err   (cfg_err)
  );

  always #5 vin_clk = ~vin_clk;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] frame_px [$];
  logic [DW-1:0] exp_q [$];
  int            out_cnt   = 0;
  int            exp_total = 0;
  int            cur_xo    = 1;
  int            bp_pct    = 0;
  bit            mon_en    = 1'b0;
  logic          exp_err   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Downstream ready: random backpressure at bp_pct percent.
  initial begin
    vout_if.ready = 1'b1;
    forever begin
      @(posedge vin_clk);
      #1;
      vout_if.ready = ($urandom_range(99) >= bp_pct);
    end
  end

  // Output monitor: scoreboard compare, stall stability and gap-free streaming.
  initial begin
    logic [DW-1:0] prev_dat;
    bit            prev_stall, prev_mid;
    prev_dat = '0; prev_stall = 1'b0; prev_mid = 1'b0;
    forever begin
      @(negedge vin_clk);
      if (mon_en) begin
        if (prev_stall) begin
          check("stall_valid", 32'(vout_if.valid), 32'd1);
          check("stall_dat", 32'(vout_if.dat), 32'(prev_dat));
        end
        if (prev_mid && bp_pct == 0) check("no_gap", 32'(vout_if.valid), 32'd1);
        prev_stall = vout_if.valid && !vout_if.ready;
        prev_dat   = vout_if.dat;
        prev_mid   = 1'b0;
        if (vout_if.valid && vout_if.ready) begin
          if (exp_q.size() == 0) check("extra_out", 32'(vout_if.valid), 32'd0);
          else check($sformatf("pixel%0d", out_cnt), 32'(vout_if.dat), 32'(exp_q.pop_front()));
          prev_mid = (cur_xo > 0) && ((out_cnt % cur_xo) != cur_xo - 1);
          out_cnt++;
        end
      end else begin
        prev_stall = 1'b0;
        prev_mid   = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Latch a new configuration with a frame_vs pulse and build the reference output.
  task automatic start_frame(input int xi, input int yi, input int xo, input int yo, input int bp);
    logic [DW-1:0] p;
    bit            ok;
    vin_if.valid = 1'b0;
    mon_en       = 1'b0;
    vin_xres = 16'(xi); vin_yres = 16'(yi); vout_xres = 16'(xo); vout_yres = 16'(yo);
    frame_vs = 1'b1;
    @(posedge vin_clk);
    #1;
    frame_vs = 1'b0;
    ok = (xi > 0) && (yi > 0) && (xo > 0) && (yo > 0) && (xo >= xi) && (yo >= yi) && (xi <= 1920);
    exp_err = !ok;
    frame_px.delete();
    exp_q.delete();
    for (int r = 0; r < yi; r++)
      for (int c = 0; c < xi; c++)
        frame_px.push_back({1'($urandom_range(1)), 8'($urandom), 8'(r), 8'(c)});
    if (ok)
      for (int r = 0; r < yo; r++)
        for (int k = 0; k < xo; k++) begin
          p = frame_px[(r * yi / yo) * xi + (k * xi / xo)];
`ifdef VIDEO_SCALE_UP_EOL_FLAG_EN
          p[DW-1] = (k == xo - 1);
`endif
          exp_q.push_back(p);
        end
    exp_total = ok ? xo * yo : 0;
    out_cnt   = 0;
    cur_xo    = xo;
    bp_pct    = bp;
    check("flush_valid", 32'(vout_if.valid), 32'd0);
    check("cfg_err", 32'(cfg_err), 32'(exp_err));
    mon_en = 1'b1;
  endtask

  // Push frame_px[0..n_px-1]; stops early once out_cnt reaches stop_at (if >= 0).
  task automatic drive_frame(input int n_px, input int gap_pct, input int stop_at,
                             input bit lat_chk, input int lat_idx, output bit aborted);
    bit acc;
    int wait_cyc;
    aborted = 1'b0;
    for (int i = 0; i < n_px; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        vin_if.valid = 1'b0;
        @(posedge vin_clk);
        #1;
      end
      vin_if.dat   = frame_px[i];
      vin_if.valid = 1'b1;
      acc          = 1'b0;
      wait_cyc     = 0;
      while (!acc) begin
        if (stop_at >= 0 && out_cnt >= stop_at) begin
          aborted = 1'b1;
          return;
        end
        @(negedge vin_clk);
        acc = vin_if.ready;
        @(posedge vin_clk);
        #1;
        wait_cyc++;
        if (!acc && wait_cyc > 5000) begin
          check($sformatf("accept_timeout_px%0d", i), 32'(wait_cyc), 32'd0);
          vin_if.valid = 1'b0;
          aborted = 1'b1;
          return;
        end
      end
      if (lat_chk && i == lat_idx) begin
        vin_if.valid = 1'b0;
        @(negedge vin_clk); check("first_lat_c1", 32'(vout_if.valid), 32'd0);
        @(negedge vin_clk); check("first_lat_c2", 32'(vout_if.valid), 32'd0);
        @(negedge vin_clk); check("first_lat_c3", 32'(vout_if.valid), 32'd1);
        @(posedge vin_clk);
        #1;
      end
    end
    vin_if.valid = 1'b0;
  endtask

  // Drain, then feed surplus input: it must be swallowed without producing output.
  task automatic finish_frame(input int xi, input int xo);
    int t;
    bit ab;
    t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      @(posedge vin_clk);
      #1;
      t++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    check("out_count", 32'(out_cnt), 32'(exp_total));
    if (xi > 0) drive_frame(xi, 0, -1, 1'b0, 0, ab);
    repeat (2 * xo + 10) @(posedge vin_clk);
    #1;
    check("drop_ready", 32'(vin_if.ready), 32'd1);
    check("idle_valid", 32'(vout_if.valid), 32'd0);
    check("cfg_err_hold", 32'(cfg_err), 32'(exp_err));
  endtask

  task automatic run_frame(input int xi, input int yi, input int xo, input int yo,
                           input int bp, input int gap, input bit lat_chk);
    bit ab;
    start_frame(xi, yi, xo, yo, bp);
    drive_frame(xi * yi, gap, -1, lat_chk, xi - 1, ab);
    finish_frame(xi, xo);
  endtask

  initial begin
    int t;
    bit ab;
    int xi, yi, xo, yo;
    vin_if.valid = 1'b0;
    vin_if.dat   = '0;
    repeat (3) @(posedge vin_clk);
    #1;
    check("rst_vin_ready", 32'(vin_if.ready), 32'd1);
    check("rst_vout_valid", 32'(vout_if.valid), 32'd0);
    check("rst_vout_dat", 32'(vout_if.dat), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    rst_n = 1'b1;
    @(posedge vin_clk);
    #1;

    // x3 horizontal, 2.25 vertical; first-pixel latency on line 0.
    run_frame(8, 4, 24, 9, 0, 0, 1'b1);
    // Identity, then heavy backpressure with input gaps.
    run_frame(16, 6, 16, 6, 0, 0, 1'b0);
    run_frame(12, 6, 24, 12, 50, 30, 1'b0);

    for (int n = 0; n < 5; n++) begin
      xi = $urandom_range(1, 20);
      yi = $urandom_range(1, 6);
      xo = xi + $urandom_range(0, 20);
      yo = yi + $urandom_range(0, 8);
      run_frame(xi, yi, xo, yo, (n % 3) * 30, (n % 2) * 30, 1'b0);
    end

    // Restart in the middle of output line 5 of a 16-wide frame.
    start_frame(8, 8, 16, 16, 30);
    drive_frame(64, 20, 5 * 16 + 7, 1'b0, 0, ab);
    t = 0;
    while (out_cnt < 5 * 16 + 7 && t < 20000) begin
      @(posedge vin_clk);
      #1;
      t++;
    end
    check("restart_point", 32'(out_cnt), 32'(5 * 16 + 7));
    run_frame(10, 5, 20, 10, 30, 0, 1'b0);

    // Invalid configurations: downscale, zero size, line wider than the buffer.
    run_frame(16, 8, 8, 4, 0, 0, 1'b0);
    run_frame(0, 4, 8, 8, 0, 0, 1'b0);
    run_frame(2000, 2, 2000, 2, 0, 0, 1'b0);

    // A valid frame after the invalid ones must recover.
    run_frame(6, 3, 13, 7, 20, 10, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/video_scale_up_near.md
# video_scale_up_near

Nearest-neighbour video upscaler: accepts a raster of `vin_xres` x `vin_yres` pixels and emits `vout_xres` x `vout_yres` pixels by repeating input pixels horizontally and input lines vertically. It sits on the display path after the frame buffer reader and before the HDMI timing generator. It is the counterpart of the downscaler on the capture path. Input lines are stored in a one-line buffer and replayed as often as the vertical ratio requires, so input is back-pressured through `vin_ready`.

## Interface
- `DW`, 25: pixel data width; bit 24 is a flag bit carried with the pixel.
- `MAX_XRES`, 1920: line buffer depth in pixels.
- `AW`, 11: line buffer address width, where `2**AW >= MAX_XRES`.
- `vin_clk`  in  1: the single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `frame_vs`  in  1: frame sync; a rising edge starts a new frame.
- `vin_dat`  in  DW: input pixel.
- `vin_valid`  in  1: input pixel valid.
- `vin_ready`  out  1: block accepts the input pixel.
- `vout_dat`  out  DW: output pixel.
- `vout_valid`  out  1: output pixel valid.
- `vout_ready`  in  1: downstream accepts the output pixel.
- `vin_xres`, `vin_yres`, `vout_xres`, `vout_yres`  in  16 each: resolutions; latched on the `frame_vs` rising edge.
- `cfg_err`  out  1: the latched configuration is invalid.

## Operation
- Transfers happen on `valid & ready`.
- `vout_dat` is held stable while `vout_valid=1 & vout_ready=0`.
- `vout_valid` never drops without a transfer.
- The config is invalid when any resolution is 0, `vout_xres<vin_xres`, `vout_yres<vin_yres`, or `vin_xres>MAX_XRES`. When invalid, `cfg_err=1` and the FSM stays in DROP.
- FSM states:
  - WAIT_VS: reset state. `vin_ready=1`; input is discarded.
  - FILL: `vin_ready=1`. Each accepted pixel is written to `buf[wr_addr]` and `wr_addr` increments. After `vin_xres` writes, go to EMIT.
  - EMIT: `vin_ready=0`. Reads `vout_xres` pixels.
    - `rd_addr` and `hacc` start at 0.
    - Per issued read: `hacc+=vin_xres`; if `hacc>=vout_xres`, then `hacc-=vout_xres` and `rd_addr++`.
    - Output pixel k therefore equals input pixel `floor(k*vin_xres/vout_xres)`.
    - At line end, `orow++` and `vacc+=vin_yres`:
      - `orow==vout_yres`: go to DROP.
      - else if `vacc>=vout_yres`: `vacc-=vout_yres`, go to FILL.
      - else: repeat EMIT from the same buffer.
  - DROP: frame complete. `vin_ready=1`; surplus input is discarded.
- A `frame_vs` rising edge, detected with a one-cycle delayed copy, has priority in any state:
  - latch the config;
  - clear `wr_addr`, `rd_addr`, `hacc`, `vacc` and `orow`;
  - flush the output stage;
  - go to FILL, or to DROP if the config is invalid.
- Accumulators are 17 bits; they never exceed `2*vout_res`. No division hardware is used.

## Timing
- Reset values: `vin_ready=1` (WAIT_VS), `vout_valid=0`, `vout_dat=0`, `cfg_err=0`; all counters 0.
- The line buffer has 1-cycle synchronous read latency.
- The output stage is a 2-entry FIFO. A read is issued only when FIFO occupancy plus in-flight reads is less than 2.
- First output pixel of a line: `vout_valid=1` 2 cycles after the EMIT entry edge.
- With `vout_ready` held high, EMIT produces one pixel per cycle with no gaps.
- EMIT→FILL and EMIT→EMIT transitions add 2 bubble cycles per line.
- EMIT leaves only after the last pixel of the line has been transferred.
- The last `vin_xres`-th write and the FILL→EMIT transition occur in the same cycle.
- A `frame_vs` edge coinciding with an input or output transfer: the transfer is completed on the bus, but its data is dropped.

## Configuration
- `VIDEO_SCALE_UP_EOL_FLAG_EN`
  - Defined: `vout_dat[24]` is forced to 1 on the last pixel of every output line and to 0 elsewhere.
  - Undefined: bit 24 passes through from the buffered input pixel unchanged.

## Structure
- Shared package `video_scale_pkg`:
  - FSM state enum (WAIT_VS, FILL, EMIT, DROP);
  - `DW` and `MAX_XRES` defaults;
  - config-check function.
- One sub-module, `video_line_buf`: simple dual-port RAM with one write port, one registered read port, `MAX_XRES` x `DW`.
- The FSM, accumulators and output FIFO live in the top level.

## Test plan
- Scaling: 640x480 to 1920x1080, input `pixel = {row[7:0], col[7:0]}`. Required: output row 0 is cols 0,0,0,1,1,1,…; output rows 0–2 come from input row 0 and row 3 from row 1 (ratio 2.25); exactly 1080x1920 outputs, then DROP.
- Identity: 1920x1080 to 1920x1080. Required: output stream equals input stream bit-exact; `cfg_err=0`.
- Backpressure: 960x540 to 1920x1080 with `vout_ready` randomly low 50% of cycles. Required: no pixel lost or duplicated beyond the 2x2 replication; `vout_dat` stable while stalled.
- Mid-frame restart: `frame_vs` rising edge in the middle of output line 100. Required: output FIFO flushed; the next output is pixel (0,0) of the new frame after a full input line.
- Invalid config: 1920x1080 to 1024x768. Required: `cfg_err=1`, `vin_ready=1`, `vout_valid` stays 0 for the whole frame.
- EOL flag: with `VIDEO_SCALE_UP_EOL_FLAG_EN` defined, 640x480 to 1280x720. Required: bit 24 = 1 only on output pixels 1279, 2559, …; without the macro, bit 24 mirrors the input flag.
